// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the word-indexed PC, captures fetched words into IF/ID,
// applies redirects (jr > jump > branch) over stalls, and halts on a fetched HALT_WORD.
module fetch_stage #(
  parameter int          MEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc1,
  input  logic [15:0] branch_offset,
  input  logic        jump_en,
  input  logic [25:0] jump_target,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc1,
  output logic        ifid_valid,
  output logic        halted
);

  localparam logic [31:0] PC_MASK = 32'(MEM_DEPTH - 1);

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e      state_q;
  logic [31:0] pc_q, ifid_instr_q, ifid_pc1_q;
  logic        ifid_valid_q;

  logic        redirect;
  logic [31:0] redir_pc_d, pc_inc_d, branch_sum;

  always_comb begin
    branch_sum = branch_pc1 + {{16{branch_offset[15]}}, branch_offset};
    pc_inc_d   = (pc_q + 32'd1) & PC_MASK;
    redirect   = jr_en | jump_en | branch_taken;
    // Control resolution order: the oldest redirecting instruction wins.
    if (jr_en)        redir_pc_d = jr_target & PC_MASK;
    else if (jump_en) redir_pc_d = {6'd0, jump_target} & PC_MASK;
    else              redir_pc_d = branch_sum & PC_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC & PC_MASK;
      ifid_instr_q <= NOP_WORD;
      ifid_pc1_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (redirect) begin
            pc_q         <= redir_pc_d;
            ifid_instr_q <= NOP_WORD;
            ifid_valid_q <= 1'b0;
          end else if (stall) begin
            pc_q <= pc_q;
          end else if (instr == HALT_WORD) begin
            ifid_instr_q <= NOP_WORD;
            ifid_valid_q <= 1'b0;
            state_q      <= S_HALT;
          end else begin
            pc_q         <= pc_inc_d;
            ifid_instr_q <= instr;
            ifid_pc1_q   <= pc_inc_d;
            ifid_valid_q <= 1'b1;
          end
        end
        S_HALT: begin
          ifid_instr_q <= NOP_WORD;
          ifid_valid_q <= 1'b0;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign pc         = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc1   = ifid_pc1_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an abstract fetch model checked every cycle, plus
// literal expectations from the test plan that pin the model itself.
module tb_fetch_stage;
  localparam int          DEPTH = 32;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam logic [31:0] NOPW  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump_en, jr_en;
  logic [31:0] branch_pc1, jr_target;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] pc, ifid_instr, ifid_pc1, instr;
  logic        ifid_valid, halted;

  logic [31:0] mem [DEPTH];
  int passed = 0, total = 0;

  // Model state: plain integers following the fetch rules.
  int unsigned m_pc, m_instr, m_pc1;
  bit          m_valid, m_halt;

  always #5 clk = ~clk;

  assign instr = mem[pc[4:0]];

  fetch_stage #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instr(instr), .stall(stall),
    .branch_taken(branch_taken), .branch_pc1(branch_pc1), .branch_offset(branch_offset),
    .jump_en(jump_en), .jump_target(jump_target), .jr_en(jr_en), .jr_target(jr_target),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc1(ifid_pc1), .ifid_valid(ifid_valid),
    .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  always @(posedge clk) begin
    int unsigned tgt;
    if (reset) begin
      m_pc = 0; m_instr = NOPW; m_pc1 = 0; m_valid = 0; m_halt = 0;
    end else if (m_halt) begin
      m_instr = NOPW; m_valid = 0;
    end else if (jr_en || jump_en || branch_taken) begin
      if (jr_en)        tgt = jr_target;
      else if (jump_en) tgt = int'(jump_target);
      else              tgt = branch_pc1 + unsigned'(int'($signed(branch_offset)));
      m_pc = tgt % DEPTH; m_instr = NOPW; m_valid = 0;
    end else if (stall) begin
      // hold
    end else if (mem[m_pc] == HALTW) begin
      m_instr = NOPW; m_valid = 0; m_halt = 1;
    end else begin
      m_instr = mem[m_pc];
      m_pc    = (m_pc + 1) % DEPTH;
      m_pc1   = m_pc; m_valid = 1;
    end
  end

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    if (m_valid) chk("ifid_pc1", ifid_pc1, m_pc1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump_en = 0; jr_en = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + i;
    reset = 1; idle();
    branch_pc1 = 0; branch_offset = 0; jump_target = 0; jr_target = 0;

    // T1: reset held two cycles, then sequential fetch
    cyc(2);
    chk("T1 rst pc", pc, 32'd0);
    chk("T1 rst valid", {31'd0, ifid_valid}, 32'd0);
    chk("T1 rst instr", ifid_instr, NOPW);
    reset = 0;
    cyc(1);
    chk("T1 pc1", pc, 32'd1);
    chk("T1 instrA", ifid_instr, 32'hA000_0000);
    chk("T1 valid", {31'd0, ifid_valid}, 32'd1);
    cyc(2);
    chk("T1 pc3", pc, 32'd3);
    chk("T1 instrC", ifid_instr, 32'hA000_0002);
    chk("T1 ifid_pc1", ifid_pc1, 32'd3);

    // T3: stall at pc=5 for three cycles
    cyc(2);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("T3 stall pc", pc, 32'd5);
      chk("T3 stall instr", ifid_instr, 32'hA000_0004);
    end
    stall = 0;
    cyc(1);
    chk("T3 resume pc", pc, 32'd6);

    // T4: branch backwards, then forward with wrap
    branch_taken = 1; branch_pc1 = 10; branch_offset = 16'hFFFC;
    cyc(1);
    chk("T4 back pc", pc, 32'd6);
    chk("T4 flush valid", {31'd0, ifid_valid}, 32'd0);
    chk("T4 flush instr", ifid_instr, NOPW);
    branch_offset = 16'h0030;
    cyc(1);
    chk("T4 fwd pc", pc, 32'd26);
    idle();

    // T2: walk to 31 and wrap
    cyc(5);
    chk("T2 pc31", pc, 32'd31);
    cyc(1);
    chk("T2 wrap pc", pc, 32'd0);
    chk("T2 wrap instr", ifid_instr, 32'hA000_001F);
    chk("T2 wrap pc1", ifid_pc1, 32'd0);

    // T5: jr beats jump beats stall
    jr_en = 1; jr_target = 20; jump_en = 1; jump_target = 3; stall = 1;
    cyc(1);
    chk("T5 jr pc", pc, 32'd20);
    idle();
    cyc(1);
    chk("T5 next pc", pc, 32'd21);
    chk("T5 next instr", ifid_instr, 32'hA000_0014);
    jr_en = 1; jr_target = 32'hFFFF_FFE9;
    cyc(1);
    chk("T5 jr mask", pc, 32'd9);
    idle(); jump_en = 1; jump_target = 26'h3FF_FFE3;
    cyc(1);
    chk("T5 jump mask", pc, 32'd3);
    idle();

    // T6: halt word, wrong-path discard, stickiness, reset recovery
    mem[4] = HALTW;
    cyc(1);
    chk("T6 pc4", pc, 32'd4);
    branch_taken = 1; branch_pc1 = 7; branch_offset = 0;
    cyc(1);
    chk("T6 no halt", {31'd0, halted}, 32'd0);
    chk("T6 br pc", pc, 32'd7);
    idle(); jump_en = 1; jump_target = 4;
    cyc(1);
    idle();
    cyc(1);
    chk("T6 halted", {31'd0, halted}, 32'd1);
    chk("T6 hold pc", pc, 32'd4);
    jr_en = 1; jr_target = 20; stall = 1; branch_taken = 1;
    cyc(2);
    chk("T6 ignore pc", pc, 32'd4);
    chk("T6 ignore valid", {31'd0, ifid_valid}, 32'd0);
    reset = 1;
    cyc(1);
    chk("T6 rst halted", {31'd0, halted}, 32'd0);
    chk("T6 rst pc", pc, 32'd0);
    reset = 0; idle();
    cyc(2);
    chk("T6 rerun pc", pc, 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
